// File: rtl/riscie_pkg.sv
// Shared definitions for the riscie pipeline: major opcodes, immediate
// format selector and a 32->64 bit sign-extension helper.
package riscie_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// NREGS x XLEN register file with two asynchronous read ports and x0 hardwired
// to zero. DECODE_WB_BYPASS_EN forwards a same-cycle writeback to the readers.
module decode_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RAW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RAW-1:0]  ra1,
    input  logic [RAW-1:0]  ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [RAW-1:0]  wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem_r [NREGS];

    // Storage: reset clears every entry; writes to x0 are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (wa != {RAW{1'b0}})) begin
            mem_r[wa] <= wd;
        end
    end

    // Read port 1.
    always_comb begin
        rd1 = {XLEN{1'b0}};
        if (ra1 == {RAW{1'b0}}) begin
            rd1 = {XLEN{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
`endif
        end else begin
            rd1 = mem_r[ra1];
        end
    end

    // Read port 2.
    always_comb begin
        rd2 = {XLEN{1'b0}};
        if (ra2 == {RAW{1'b0}}) begin
            rd2 = {XLEN{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
`endif
        end else begin
            rd2 = mem_r[ra2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// riscie ID stage: register read, immediate generation, load-use hazard and
// the ID/EX register. Optional macro DECODE_WB_BYPASS_EN (see decode_regfile).
module decode_stage
    import riscie_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RAW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifid_valid,
    input  logic [31:0]     ifid_inst,
    input  logic [XLEN-1:0] ifid_pc,
    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_flush,
    output logic            stall,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [XLEN-1:0] idex_rs1_data,
    output logic [XLEN-1:0] idex_rs2_data,
    output logic [RAW-1:0]  idex_rs1,
    output logic [RAW-1:0]  idex_rs2,
    output logic [RAW-1:0]  idex_rd,
    output logic [2:0]      idex_funct3,
    output logic [6:0]      idex_funct7,
    output logic [6:0]      idex_opcode,
    output logic [XLEN-1:0] idex_imm,
    output logic            idex_mem_read
);

    logic [6:0]      opcode_s;
    logic [RAW-1:0]  rs1_s, rs2_s, rd_s;
    logic [XLEN-1:0] rs1_data_s, rs2_data_s;
    logic            uses_rs1_s, uses_rs2_s, is_load_s, hit_s;
    imm_fmt_t        imm_fmt_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] imm_s;

    logic            idex_valid_r, idex_mem_read_r;
    logic [XLEN-1:0] idex_pc_r, idex_rs1_data_r, idex_rs2_data_r, idex_imm_r;
    logic [RAW-1:0]  idex_rs1_r, idex_rs2_r, idex_rd_r;
    logic [2:0]      idex_funct3_r;
    logic [6:0]      idex_funct7_r, idex_opcode_r;

    assign opcode_s = ifid_inst[6:0];
    assign rd_s     = ifid_inst[7  +: RAW];
    assign rs1_s    = ifid_inst[15 +: RAW];
    assign rs2_s    = ifid_inst[20 +: RAW];

    decode_regfile #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .RAW  (RAW)
    ) u_regfile (
        .clk(clk),
        .rst(rst),
        .ra1(rs1_s),
        .ra2(rs2_s),
        .rd1(rs1_data_s),
        .rd2(rs2_data_s),
        .we (wb_en),
        .wa (wb_rd),
        .wd (wb_data)
    );

    // Opcode classification: operand usage, load flag, immediate format.
    always_comb begin
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b0;
        is_load_s  = 1'b0;
        imm_fmt_s  = IMM_NONE;
        case (opcode_s)
            OPC_LOAD: begin
                imm_fmt_s = IMM_I;
                is_load_s = 1'b1;
            end
            OPC_OP_IMM, OPC_JALR: imm_fmt_s = IMM_I;
            OPC_STORE: begin
                imm_fmt_s  = IMM_S;
                uses_rs2_s = 1'b1;
            end
            OPC_BRANCH: begin
                imm_fmt_s  = IMM_B;
                uses_rs2_s = 1'b1;
            end
            OPC_OP: uses_rs2_s = 1'b1;
            OPC_LUI, OPC_AUIPC: begin
                imm_fmt_s  = IMM_U;
                uses_rs1_s = 1'b0;
            end
            OPC_JAL: begin
                imm_fmt_s  = IMM_J;
                uses_rs1_s = 1'b0;
            end
            default: imm_fmt_s = IMM_NONE;
        endcase
    end

    // 32-bit immediate assembly; every format carries its sign in inst[31].
    always_comb begin
        imm32_s = 32'd0;
        case (imm_fmt_s)
            IMM_I: imm32_s = {{20{ifid_inst[31]}}, ifid_inst[31:20]};
            IMM_S: imm32_s = {{20{ifid_inst[31]}}, ifid_inst[31:25], ifid_inst[11:7]};
            IMM_B: imm32_s = {{19{ifid_inst[31]}}, ifid_inst[31], ifid_inst[7],
                              ifid_inst[30:25], ifid_inst[11:8], 1'b0};
            IMM_U: imm32_s = {ifid_inst[31:12], 12'd0};
            IMM_J: imm32_s = {{11{ifid_inst[31]}}, ifid_inst[31], ifid_inst[19:12],
                              ifid_inst[20], ifid_inst[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    if (XLEN == 64) begin : g_imm64
        assign imm_s = sext32(imm32_s);
    end else begin : g_imm32
        assign imm_s = imm32_s;
    end

    // A load in EX whose destination is read here costs one bubble; flush and reset override.
    assign hit_s = (uses_rs1_s && (rs1_s == idex_rd_r)) ||
                   (uses_rs2_s && (rs2_s == idex_rd_r));
    assign stall = !rst && !ex_flush && ifid_valid && idex_valid_r &&
                   idex_mem_read_r && (idex_rd_r != {RAW{1'b0}}) && hit_s;

    // ID/EX register: reset, then flush/stall bubble, then normal capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_valid_r    <= 1'b0;
            idex_mem_read_r <= 1'b0;
            idex_pc_r       <= {XLEN{1'b0}};
            idex_rs1_data_r <= {XLEN{1'b0}};
            idex_rs2_data_r <= {XLEN{1'b0}};
            idex_imm_r      <= {XLEN{1'b0}};
            idex_rs1_r      <= {RAW{1'b0}};
            idex_rs2_r      <= {RAW{1'b0}};
            idex_rd_r       <= {RAW{1'b0}};
            idex_funct3_r   <= 3'd0;
            idex_funct7_r   <= 7'd0;
            idex_opcode_r   <= 7'd0;
        end else if (ex_flush || stall) begin
            idex_valid_r    <= 1'b0;
            idex_mem_read_r <= 1'b0;
        end else begin
            idex_valid_r    <= ifid_valid;
            idex_mem_read_r <= ifid_valid && is_load_s;
            idex_pc_r       <= ifid_pc;
            idex_rs1_data_r <= rs1_data_s;
            idex_rs2_data_r <= rs2_data_s;
            idex_imm_r      <= imm_s;
            idex_rs1_r      <= rs1_s;
            idex_rs2_r      <= rs2_s;
            idex_rd_r       <= rd_s;
            idex_funct3_r   <= ifid_inst[14:12];
            idex_funct7_r   <= ifid_inst[31:25];
            idex_opcode_r   <= opcode_s;
        end
    end

    assign idex_valid    = idex_valid_r;
    assign idex_mem_read = idex_mem_read_r;
    assign idex_pc       = idex_pc_r;
    assign idex_rs1_data = idex_rs1_data_r;
    assign idex_rs2_data = idex_rs2_data_r;
    assign idex_imm      = idex_imm_r;
    assign idex_rs1      = idex_rs1_r;
    assign idex_rs2      = idex_rs2_r;
    assign idex_rd       = idex_rd_r;
    assign idex_funct3   = idex_funct3_r;
    assign idex_funct7   = idex_funct7_r;
    assign idex_opcode   = idex_opcode_r;

endmodule
